alu_top: RTL and testbench

8-bit, four-operation arithmetic unit with a start/done handshake. ADD and SUB complete in one execute cycle. MUL uses radix-2 signed Booth, DIV uses unsigned restoring division, and both run iteratively over 8 cycles. It sits as a coprocessor-style block: the controller drives operands and opcode, pulses `start`, then reads `outbus` while `done` is high.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_muldiv_unit.sv | 100 ++++++++++
 rtl/alu_top.sv | 124 ++++++++++++
 tb/tb_alu_top.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the alu_top coprocessor block.
//   WIDTH      : operand/result width
//   ITER_COUNT : iterations for MUL (Booth) and DIV (restoring)
//   OP_*       : opcode encodings
//   state_t    : control FSM states
package alu_pkg;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned ITER_COUNT = 8;
  localparam int unsigned CNT_W      = $clog2(ITER_COUNT);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_EXEC   = 2'b01,
    ST_OUT_LO = 2'b10,
    ST_OUT_HI = 2'b11
  } state_t;

  // MUL and DIV share the iterative unit; ADD and SUB do not.
  function automatic logic is_muldiv(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/alu_muldiv_unit.sv
// Iterative multiply/divide datapath shared by MUL and DIV.
//   clk, reset : clock, async active-low reset
//   load       : capture operands and mode, clear counter
//   step       : perform one Booth or restoring iteration
//   mode       : 0 = signed Booth multiply, 1 = unsigned restoring divide
//   a, b       : operands (multiplicand/dividend, multiplier/divisor)
//   lo, hi     : result words (Q and AC registers)
//   last_c     : current step is the final iteration
module alu_muldiv_unit #(
  parameter int unsigned W = alu_pkg::WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic         mode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output logic         last_c
);
  import alu_pkg::*;

  logic [W-1:0]     ac;
  logic [W-1:0]     q;
  logic             q_m1;
  logic [W-1:0]     m;
  logic [CNT_W-1:0] cnt;
  logic             mode_q;

  logic [W-1:0] ac_sum;
  logic [W-1:0] booth_ac;
  logic [W-1:0] booth_q;
  logic [W:0]   rem_sh;
  logic [W+1:0] rem_diff;
  logic [W-1:0] div_ac;
  logic [W-1:0] div_q;

  // Booth step: add/subtract M on the (Q0,Q-1) pair, then arithmetic shift.
  always_comb begin
    ac_sum = ac;
    unique case ({q[0], q_m1})
      2'b10:   ac_sum = ac - m;
      2'b01:   ac_sum = ac + m;
      default: ac_sum = ac;
    endcase
    booth_ac = {ac_sum[W-1], ac_sum[W-1:1]};
    booth_q  = {ac_sum[0], q[W-1:1]};
  end

  // Restoring step: the shifted remainder needs one extra bit, the
  // difference one more for the sign. A zero divisor naturally yields
  // an all-ones quotient with the dividend left in the remainder.
  always_comb begin
    rem_sh   = {ac, q[W-1]};
    rem_diff = {1'b0, rem_sh} - {2'b00, m};
    if (rem_diff[W+1]) begin
      div_ac = rem_sh[W-1:0];
      div_q  = {q[W-2:0], 1'b0};
    end else begin
      div_ac = rem_diff[W-1:0];
      div_q  = {q[W-2:0], 1'b1};
    end
  end

  // Datapath registers and iteration counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ac     <= '0;
      q      <= '0;
      q_m1   <= 1'b0;
      m      <= '0;
      cnt    <= '0;
      mode_q <= 1'b0;
    end else if (load) begin
      ac     <= '0;
      q      <= mode ? a : b;
      q_m1   <= 1'b0;
      m      <= mode ? b : a;
      cnt    <= '0;
      mode_q <= mode;
    end else if (step) begin
      cnt <= cnt + CNT_W'(1);
      if (mode_q) begin
        ac <= div_ac;
        q  <= div_q;
      end else begin
        ac   <= booth_ac;
        q    <= booth_q;
        q_m1 <= q[0];
      end
    end
  end

  assign last_c = step && (cnt == CNT_W'(ITER_COUNT - 1));
  assign lo     = q;
  assign hi     = ac;

endmodule

// File: rtl/alu_top.sv
// Four-operation arithmetic coprocessor with start/done handshake.
//   clk     : clock, rising edge
//   reset   : async active-low reset
//   start   : request, honoured only in IDLE
//   opcode  : 00 ADD, 01 SUB, 10 MUL, 11 DIV
//   inbus_a : operand A
//   inbus_b : operand B
//   outbus  : registered result word, held while idle
//   done    : high while outbus carries a result word
module alu_top #(
  parameter int unsigned WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       opcode,
  input  logic [WIDTH-1:0] inbus_a,
  input  logic [WIDTH-1:0] inbus_b,
  output logic [WIDTH-1:0] outbus,
  output logic             done
);
  import alu_pkg::*;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] addsub_q;
  logic [WIDTH-1:0] outbus_nxt;
  logic             done_nxt;

  logic             accept_c;
  logic             md_step_c;
  logic             md_last_c;
  logic [WIDTH-1:0] md_lo;
  logic [WIDTH-1:0] md_hi;

  assign accept_c  = (state == ST_IDLE) && start;
  assign md_step_c = (state == ST_EXEC) && is_muldiv(op_q);

  alu_muldiv_unit #(
    .W (WIDTH)
  ) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .load   (accept_c),
    .step   (md_step_c),
    .mode   (opcode == OP_DIV),
    .a      (inbus_a),
    .b      (inbus_b),
    .lo     (md_lo),
    .hi     (md_hi),
    .last_c (md_last_c)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and next output values.
  always_comb begin
    state_nxt  = state;
    outbus_nxt = outbus;
    done_nxt   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        if (!is_muldiv(op_q) || md_last_c) state_nxt = ST_OUT_LO;
      end
      ST_OUT_LO: begin
        done_nxt = 1'b1;
        if (is_muldiv(op_q)) begin
          outbus_nxt = md_lo;
          state_nxt  = ST_OUT_HI;
        end else begin
          outbus_nxt = addsub_q;
          state_nxt  = ST_IDLE;
        end
      end
      ST_OUT_HI: begin
        done_nxt   = 1'b1;
        outbus_nxt = md_hi;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outbus <= '0;
      done   <= 1'b0;
    end else begin
      outbus <= outbus_nxt;
      done   <= done_nxt;
    end
  end

  // Request latch and single-cycle ADD/SUB datapath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      addsub_q <= '0;
    end else if (accept_c) begin
      op_q <= opcode;
      a_q  <= inbus_a;
      b_q  <= inbus_b;
    end else if ((state == ST_EXEC) && !is_muldiv(op_q)) begin
      addsub_q <= (op_q == OP_SUB) ? (a_q - b_q) : (a_q + b_q);
    end
  end

endmodule

// File: tb/tb_alu_top.sv
// Directed, table-driven bench for alu_top.
module tb_alu_top;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] lo;
    logic [7:0] hi;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] opcode;
  logic [7:0] inbus_a;
  logic [7:0] inbus_b;
  logic [7:0] outbus;
  logic       done;

  int n_checks;
  int n_pass;

  alu_top dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .opcode  (opcode),
    .inbus_a (inbus_a),
    .inbus_b (inbus_b),
    .outbus  (outbus),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // Apply one request and check every cycle of its result window.
  // With noise set, a second conflicting start is held high during the run.
  task automatic run_vec(input string tag, input vec_t v, input bit noise);
    opcode  = v.op;
    inbus_a = v.a;
    inbus_b = v.b;
    start   = 1'b1;
    tick();
    start = 1'b0;
    if (noise) begin
      opcode  = 2'b00;
      inbus_a = 8'h77;
      inbus_b = 8'h11;
      start   = 1'b1;
    end
    if (v.op[1]) begin
      for (int e = 1; e <= 8; e++) begin
        tick();
        if (e == 4) check({tag, "_busy4"}, {7'b0, done}, 8'h00);
      end
      start = 1'b0;
      check({tag, "_busy8"}, {7'b0, done}, 8'h00);
      tick();
      check({tag, "_done9"}, {7'b0, done}, 8'h01);
      check({tag, "_lo"}, outbus, v.lo);
      tick();
      check({tag, "_done10"}, {7'b0, done}, 8'h01);
      check({tag, "_hi"}, outbus, v.hi);
      tick();
      check({tag, "_done11"}, {7'b0, done}, 8'h00);
      check({tag, "_hold"}, outbus, v.hi);
    end else begin
      tick();
      check({tag, "_done1"}, {7'b0, done}, 8'h00);
      tick();
      check({tag, "_done2"}, {7'b0, done}, 8'h01);
      check({tag, "_res"}, outbus, v.lo);
      tick();
      check({tag, "_done3"}, {7'b0, done}, 8'h00);
      check({tag, "_hold"}, outbus, v.lo);
    end
    start = 1'b0;
  endtask

  vec_t vecs[10];
  vec_t noisy;
  vec_t mul_abort;
  vec_t add_after;

  initial begin
    n_checks = 0;
    n_pass   = 0;

    //          op     a      b      lo     hi
    vecs[0] = '{2'b00, 8'd15,  8'd10, 8'h19, 8'h00};
    vecs[1] = '{2'b00, 8'd200, 8'd100, 8'h2C, 8'h00};
    vecs[2] = '{2'b01, 8'd25,  8'd10, 8'h0F, 8'h00};
    vecs[3] = '{2'b01, 8'd10,  8'd25, 8'hF1, 8'h00};
    vecs[4] = '{2'b10, 8'd5,   8'd6,  8'h1E, 8'h00};
    vecs[5] = '{2'b10, 8'hFD,  8'd7,  8'hEB, 8'hFF};
    vecs[6] = '{2'b10, 8'hF6,  8'hF4, 8'h78, 8'h00};
    vecs[7] = '{2'b11, 8'd30,  8'd5,  8'h06, 8'h00};
    vecs[8] = '{2'b11, 8'd255, 8'd16, 8'h0F, 8'h0F};
    vecs[9] = '{2'b11, 8'd200, 8'd0,  8'hFF, 8'hC8};

    noisy     = '{2'b11, 8'd30, 8'd5, 8'h06, 8'h00};
    mul_abort = '{2'b10, 8'd5,  8'd6, 8'h1E, 8'h00};
    add_after = '{2'b00, 8'd1,  8'd1, 8'h02, 8'h00};

    start   = 1'b0;
    opcode  = 2'b00;
    inbus_a = 8'h00;
    inbus_b = 8'h00;
    reset   = 1'b1;
    #2 reset = 1'b0;
    tick();
    tick();
    check("rst_outbus", outbus, 8'h00);
    check("rst_done", {7'b0, done}, 8'h00);
    reset = 1'b1;
    tick();

    foreach (vecs[i]) run_vec($sformatf("v%0d", i), vecs[i], 1'b0);

    // Conflicting start during DIV must not disturb the running divide.
    run_vec("div_noise", noisy, 1'b1);
    tick();
    check("noise_idle_done", {7'b0, done}, 8'h00);

    // Leave a nonzero word on outbus, then abort a MUL at edge 4.
    run_vec("pre_abort", vecs[9], 1'b0);
    opcode  = mul_abort.op;
    inbus_a = mul_abort.a;
    inbus_b = mul_abort.b;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 4; e++) tick();
    #2 reset = 1'b0;
    #1;
    check("abort_outbus", outbus, 8'h00);
    check("abort_done", {7'b0, done}, 8'h00);
    tick();
    reset = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      if (done !== 1'b0) check($sformatf("abort_quiet%0d", e), {7'b0, done}, 8'h00);
    end
    check("abort_still_zero", outbus, 8'h00);
    run_vec("after_rst", add_after, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
